// File: rtl/pipe_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_sequencer: valid/metadata tracking, hazard, flush, freeze, forwarding |
// | and retire control for a five-stage RV32 pipeline.                        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pipe_sequencer #(
   parameter int NREG_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREG_W-1:0] d_rs1,
   input  logic [NREG_W-1:0] d_rs2,
   input  logic              d_use_rs1,
   input  logic              d_use_rs2,
   input  logic [NREG_W-1:0] d_rd,
   input  logic              d_wen,
   input  logic              d_is_load,
   input  logic              x_brn_tkn,
   input  logic              mem_busy,
   output logic              pc_en,
   output logic              pc_sel_tgt,
   output logic              fd_en,
   output logic              dx_en,
   output logic              xm_en,
   output logic              mw_en,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              d_byp_a,
   output logic              d_byp_b,
   output logic              rf_wen,
   output logic [CNT_W-1:0]  retired
);

   logic              v_d_q, v_x_q, v_m_q, v_w_q;
   logic              v_d_d, v_x_d, v_m_d, v_w_d;
   logic [NREG_W-1:0] x_rd_q, x_rs1_q, x_rs2_q, m_rd_q, w_rd_q;
   logic [NREG_W-1:0] x_rd_d, x_rs1_d, x_rs2_d, m_rd_d, w_rd_d;
   logic              x_wen_q, x_is_load_q, x_use_rs1_q, x_use_rs2_q, m_wen_q, w_wen_q;
   logic              x_wen_d, x_is_load_d, x_use_rs1_d, x_use_rs2_d, m_wen_d, w_wen_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic w_hz, w_fl, w_run;
   logic w_m_a, w_w_a, w_m_b, w_w_b;

   assign w_hz = v_d_q & v_x_q & x_is_load_q & x_wen_q & (x_rd_q != '0) &
                 ((d_use_rs1 & (d_rs1 == x_rd_q)) | (d_use_rs2 & (d_rs2 == x_rd_q)));
   assign w_fl  = v_x_q & x_brn_tkn;
   // Reset gates the enables directly so they drop without waiting for a clock edge.
   assign w_run = ~reset & ~mem_busy;

   always_comb begin
      pc_en      = 1'b0;
      pc_sel_tgt = 1'b0;
      fd_en      = 1'b0;
      dx_en      = 1'b0;
      xm_en      = 1'b0;
      mw_en      = 1'b0;
      if (w_run) begin
         dx_en = 1'b1;
         xm_en = 1'b1;
         mw_en = 1'b1;
         if (w_fl) begin
            pc_en      = 1'b1;
            pc_sel_tgt = 1'b1;
            fd_en      = 1'b1;
         end else if (!w_hz) begin
            pc_en = 1'b1;
            fd_en = 1'b1;
         end
      end
   end

   always_comb begin
      v_d_d       = v_d_q;
      v_x_d       = v_x_q;
      v_m_d       = v_m_q;
      v_w_d       = v_w_q;
      x_rd_d      = x_rd_q;
      x_rs1_d     = x_rs1_q;
      x_rs2_d     = x_rs2_q;
      x_wen_d     = x_wen_q;
      x_is_load_d = x_is_load_q;
      x_use_rs1_d = x_use_rs1_q;
      x_use_rs2_d = x_use_rs2_q;
      m_rd_d      = m_rd_q;
      m_wen_d     = m_wen_q;
      w_rd_d      = w_rd_q;
      w_wen_d     = w_wen_q;
      retired_d   = retired_q;
      if (w_run) begin
         // Flush keeps the branch itself moving into M; hazard only bubbles X.
         if (w_fl) begin
            v_d_d = 1'b0;
            v_x_d = 1'b0;
            v_m_d = 1'b1;
            v_w_d = v_m_q;
         end else if (w_hz) begin
            v_x_d = 1'b0;
            v_m_d = v_x_q;
            v_w_d = v_m_q;
         end else begin
            v_d_d = 1'b1;
            v_x_d = v_d_q;
            v_m_d = v_x_q;
            v_w_d = v_m_q;
         end
         x_rd_d      = d_rd;
         x_rs1_d     = d_rs1;
         x_rs2_d     = d_rs2;
         x_wen_d     = d_wen;
         x_is_load_d = d_is_load;
         x_use_rs1_d = d_use_rs1;
         x_use_rs2_d = d_use_rs2;
         m_rd_d      = x_rd_q;
         m_wen_d     = x_wen_q;
         w_rd_d      = m_rd_q;
         w_wen_d     = m_wen_q;
         if (v_w_q) begin
            retired_d = retired_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v_d_q       <= 1'b0;
         v_x_q       <= 1'b0;
         v_m_q       <= 1'b0;
         v_w_q       <= 1'b0;
         x_rd_q      <= '0;
         x_rs1_q     <= '0;
         x_rs2_q     <= '0;
         x_wen_q     <= 1'b0;
         x_is_load_q <= 1'b0;
         x_use_rs1_q <= 1'b0;
         x_use_rs2_q <= 1'b0;
         m_rd_q      <= '0;
         m_wen_q     <= 1'b0;
         w_rd_q      <= '0;
         w_wen_q     <= 1'b0;
         retired_q   <= '0;
      end else begin
         v_d_q       <= v_d_d;
         v_x_q       <= v_x_d;
         v_m_q       <= v_m_d;
         v_w_q       <= v_w_d;
         x_rd_q      <= x_rd_d;
         x_rs1_q     <= x_rs1_d;
         x_rs2_q     <= x_rs2_d;
         x_wen_q     <= x_wen_d;
         x_is_load_q <= x_is_load_d;
         x_use_rs1_q <= x_use_rs1_d;
         x_use_rs2_q <= x_use_rs2_d;
         m_rd_q      <= m_rd_d;
         m_wen_q     <= m_wen_d;
         w_rd_q      <= w_rd_d;
         w_wen_q     <= w_wen_d;
         retired_q   <= retired_d;
      end
   end

   // x0 is excluded from every forward/bypass path; M wins over W.
   assign w_m_a = v_m_q & m_wen_q & (m_rd_q != '0) & (m_rd_q == x_rs1_q) & x_use_rs1_q;
   assign w_w_a = v_w_q & w_wen_q & (w_rd_q != '0) & (w_rd_q == x_rs1_q) & x_use_rs1_q;
   assign w_m_b = v_m_q & m_wen_q & (m_rd_q != '0) & (m_rd_q == x_rs2_q) & x_use_rs2_q;
   assign w_w_b = v_w_q & w_wen_q & (w_rd_q != '0) & (w_rd_q == x_rs2_q) & x_use_rs2_q;

   assign fwd_a   = w_m_a ? 2'b01 : (w_w_a ? 2'b10 : 2'b00);
   assign fwd_b   = w_m_b ? 2'b01 : (w_w_b ? 2'b10 : 2'b00);
   assign d_byp_a = v_w_q & w_wen_q & (w_rd_q != '0) & (w_rd_q == d_rs1);
   assign d_byp_b = v_w_q & w_wen_q & (w_rd_q != '0) & (w_rd_q == d_rs2);
   assign rf_wen  = v_w_q & w_wen_q & ~mem_busy;
   assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// Testbench for pipe_sequencer: per-cycle vector table with hand-derived
// expectations, routed through a scoreboard queue, plus corner-case sequences.
module tb_pipe_sequencer;
   localparam int NREG_W = 5;
   localparam int CNT_W  = 32;
   localparam int NVEC   = 31;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREG_W-1:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;
   logic              d_use_rs1 = 1'b0, d_use_rs2 = 1'b0, d_wen = 1'b0, d_is_load = 1'b0;
   logic              x_brn_tkn = 1'b0, mem_busy = 1'b0;
   logic              pc_en, pc_sel_tgt, fd_en, dx_en, xm_en, mw_en;
   logic [1:0]        fwd_a, fwd_b;
   logic              d_byp_a, d_byp_b, rf_wen;
   logic [CNT_W-1:0]  retired;

   always #5 clk = ~clk;

   pipe_sequencer #(.NREG_W(NREG_W), .CNT_W(CNT_W)) dut (
      .clock(clk), .reset(rst),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
      .d_rd(d_rd), .d_wen(d_wen), .d_is_load(d_is_load),
      .x_brn_tkn(x_brn_tkn), .mem_busy(mem_busy),
      .pc_en(pc_en), .pc_sel_tgt(pc_sel_tgt), .fd_en(fd_en), .dx_en(dx_en),
      .xm_en(xm_en), .mw_en(mw_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .d_byp_a(d_byp_a), .d_byp_b(d_byp_b), .rf_wen(rf_wen), .retired(retired)
   );

   typedef struct packed {
      logic [5:0]       en;   // {pc_en, pc_sel_tgt, fd_en, dx_en, xm_en, mw_en}
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [1:0]       byp;  // {d_byp_a, d_byp_b}
      logic             rfw;
      logic [CNT_W-1:0] ret;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [4:0]  rd;
      logic        wen;
      logic        ld;
      logic        brn;
      logic        busy;
      exp_t        exp;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[NVEC];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   step   = 0;

   function automatic vec_t mk(input int r, input int rs1, input int rs2, input int u1,
                               input int u2, input int rd, input int wen, input int ld,
                               input int brn, input int busy, input int en, input int fa,
                               input int fb, input int byp, input int rfw, input int ret);
      vec_t v;
      v.rst     = r[0];
      v.rs1     = rs1[4:0];
      v.rs2     = rs2[4:0];
      v.u1      = u1[0];
      v.u2      = u2[0];
      v.rd      = rd[4:0];
      v.wen     = wen[0];
      v.ld      = ld[0];
      v.brn     = brn[0];
      v.busy    = busy[0];
      v.exp.en  = en[5:0];
      v.exp.fa  = fa[1:0];
      v.exp.fb  = fb[1:0];
      v.exp.byp = byp[1:0];
      v.exp.rfw = rfw[0];
      v.exp.ret = ret;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h, expected %0h", name, step, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst       = v.rst;
      d_rs1     = v.rs1;
      d_rs2     = v.rs2;
      d_use_rs1 = v.u1;
      d_use_rs2 = v.u2;
      d_rd      = v.rd;
      d_wen     = v.wen;
      d_is_load = v.ld;
      x_brn_tkn = v.brn;
      mem_busy  = v.busy;
      sb_q.push_back(v.exp);
      #2;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard step %0d: got empty queue, expected an entry", step);
      end else begin
         e = sb_q.pop_front();
         cmp("enables", 32'({pc_en, pc_sel_tgt, fd_en, dx_en, xm_en, mw_en}), 32'(e.en));
         cmp("fwd_a",   32'(fwd_a), 32'(e.fa));
         cmp("fwd_b",   32'(fwd_b), 32'(e.fb));
         cmp("d_byp",   32'({d_byp_a, d_byp_b}), 32'(e.byp));
         cmp("rf_wen",  32'(rf_wen), 32'(e.rfw));
         cmp("retired", retired, e.ret);
      end
      step++;
   endtask

   initial begin
      //             rst rs1 rs2 u1 u2 rd wen ld brn bsy   en       fa fb byp  rfw ret
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b000000, 0, 0, 0,    0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b000000, 0, 0, 0,    0, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b000000, 0, 0, 0,    0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 0);
      tbl[5]  = mk(0, 1, 0, 1, 0, 5, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 0);
      tbl[6]  = mk(0, 5, 0, 1, 0, 6, 1, 0, 0, 0, 'b101111, 1, 0, 0,    0, 0);
      tbl[7]  = mk(0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 'b101111, 1, 0, 'b01, 1, 0);
      tbl[8]  = mk(0, 5, 0, 1, 0, 7, 1, 1, 0, 0, 'b101111, 2, 0, 'b10, 1, 1);
      tbl[9]  = mk(0, 0, 7, 0, 1, 8, 1, 0, 0, 0, 'b000111, 0, 0, 0,    1, 2);
      tbl[10] = mk(0, 0, 7, 0, 1, 8, 1, 0, 0, 0, 'b101111, 0, 1, 0,    0, 3);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b111111, 0, 2, 0,    1, 4);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 5);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    1, 5);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 6);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 6);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b000000, 0, 0, 0,    0, 6);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b000000, 0, 0, 0,    0, 6);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b000000, 0, 0, 0,    0, 6);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b000000, 0, 0, 0,    0, 6);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b111111, 0, 0, 0,    0, 6);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 7);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 8);
      tbl[23] = mk(0, 0, 0, 1, 1, 3, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 9);
      tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    0, 9);
      tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0,    1, 9);
      tbl[26] = mk(0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 'b101111, 0, 0, 0,    1, 10);
      tbl[27] = mk(0, 9, 0, 1, 0, 4, 1, 0, 0, 0, 'b000111, 0, 0, 0,    0, 11);
      tbl[28] = mk(1, 9, 0, 1, 0, 4, 1, 0, 0, 0, 'b000000, 0, 0, 0,    0, 0);
      tbl[29] = mk(0, 9, 0, 1, 0, 4, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 0);
      tbl[30] = mk(0, 9, 0, 1, 0, 4, 1, 0, 0, 0, 'b101111, 0, 0, 0,    0, 0);

      for (int i = 0; i < NVEC; i++) begin
         apply(tbl[i]);
      end

      // Load-use pair and taken branch together: flush must win.
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b000000, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 'b101111, 0, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 1, 0, 4, 1, 0, 1, 0, 'b111111, 0, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 1, 0, 4, 1, 0, 0, 0, 'b101111, 1, 0, 0, 0, 0));

      // Freeze with a valid writer in W: no regfile write, forwarding still live.
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000000, 2, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b101111, 2, 0, 0, 1, 0));

      if (sb_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
